// File: rtl/core_v_mcu_axi_pkg.sv
// AXI channel and bundle types shared across the core_v_mcu AXI fabric.
package core_v_mcu_axi_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } axi_aw_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [USER_W-1:0] user;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    axi_b_t  b;
    logic    r_valid;
    axi_r_t  r;
  } axi_resp_t;

endpackage

// File: rtl/core_v_mcu_axi_arb2.sv
// Two-manager to one-subordinate AXI arbiter: independent round-robin read and
// write paths, one outstanding burst per direction, atomics answered locally with SLVERR.
module core_v_mcu_axi_arb2 #(
  parameter type req_t  = core_v_mcu_axi_pkg::axi_req_t,
  parameter type resp_t = core_v_mcu_axi_pkg::axi_resp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  req_t       mgr0_req_i,
  output resp_t      mgr0_resp_o,
  input  req_t       mgr1_req_i,
  output resp_t      mgr1_resp_o,
  output req_t       sub_req_o,
  input  resp_t      sub_resp_i,
  output logic [1:0] busy_o
);

  typedef enum logic [2:0] {
    W_IDLE = 3'd0, W_AW = 3'd1, W_DATA = 3'd2, W_RESP = 3'd3, E_DATA = 3'd4, E_RESP = 3'd5
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2
  } rd_state_e;

  wr_state_e wr_state_r, wr_next_s;
  rd_state_e rd_state_r, rd_next_s;
  logic      wr_ptr_r, wr_sel_r, rd_ptr_r, rd_sel_r;
  logic [$bits(mgr0_req_i.aw)-1:0]     wr_aw_r;
  logic [$bits(mgr0_req_i.ar)-1:0]     rd_ar_r;
  logic [$bits(mgr0_resp_o.b.id)-1:0]  wr_id_r;

  logic      wr_grant_s, wr_win_s, wr_win_atomic_s;
  logic      rd_grant_s, rd_win_s;
  logic      wr_sel_w_valid_s, wr_sel_w_last_s, wr_sel_b_ready_s, rd_sel_r_ready_s;
  resp_t     mgr_resp_s [2];

  // Round-robin winner selection for both directions
  always_comb begin
    wr_grant_s = (wr_state_r == W_IDLE) && (mgr0_req_i.aw_valid || mgr1_req_i.aw_valid);
    if (mgr0_req_i.aw_valid && mgr1_req_i.aw_valid) begin
      wr_win_s = wr_ptr_r;
    end else begin
      wr_win_s = mgr1_req_i.aw_valid;
    end
    wr_win_atomic_s = wr_win_s ? (mgr1_req_i.aw.atop != 6'd0) : (mgr0_req_i.aw.atop != 6'd0);
    rd_grant_s = (rd_state_r == R_IDLE) && (mgr0_req_i.ar_valid || mgr1_req_i.ar_valid);
    if (mgr0_req_i.ar_valid && mgr1_req_i.ar_valid) begin
      rd_win_s = rd_ptr_r;
    end else begin
      rd_win_s = mgr1_req_i.ar_valid;
    end
  end

  // Handshake inputs from whichever manager owns each direction
  always_comb begin
    wr_sel_w_valid_s = wr_sel_r ? mgr1_req_i.w_valid : mgr0_req_i.w_valid;
    wr_sel_w_last_s  = wr_sel_r ? mgr1_req_i.w.last  : mgr0_req_i.w.last;
    wr_sel_b_ready_s = wr_sel_r ? mgr1_req_i.b_ready : mgr0_req_i.b_ready;
    rd_sel_r_ready_s = rd_sel_r ? mgr1_req_i.r_ready : mgr0_req_i.r_ready;
  end

  // Write and read state/pointer/payload registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_state_r <= W_IDLE;
      rd_state_r <= R_IDLE;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      wr_sel_r   <= 1'b0;
      rd_sel_r   <= 1'b0;
      wr_aw_r    <= '0;
      rd_ar_r    <= '0;
      wr_id_r    <= '0;
    end else begin
      wr_state_r <= wr_next_s;
      rd_state_r <= rd_next_s;
      if (wr_grant_s) begin
        // pointer moves to the loser, or to the idle manager when uncontended
        wr_ptr_r <= ~wr_win_s;
        wr_sel_r <= wr_win_s;
        wr_aw_r  <= wr_win_s ? mgr1_req_i.aw : mgr0_req_i.aw;
        wr_id_r  <= wr_win_s ? mgr1_req_i.aw.id : mgr0_req_i.aw.id;
      end
      if (rd_grant_s) begin
        rd_ptr_r <= ~rd_win_s;
        rd_sel_r <= rd_win_s;
        rd_ar_r  <= rd_win_s ? mgr1_req_i.ar : mgr0_req_i.ar;
      end
    end
  end

  // Write FSM next state
  always_comb begin
    wr_next_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (wr_grant_s) begin
          wr_next_s = wr_win_atomic_s ? E_DATA : W_AW;
        end else begin
          wr_next_s = W_IDLE;
        end
      end
      W_AW: begin
        if (sub_resp_i.aw_ready) wr_next_s = W_DATA;
        else                     wr_next_s = W_AW;
      end
      W_DATA: begin
        if (wr_sel_w_valid_s && sub_resp_i.w_ready && wr_sel_w_last_s) wr_next_s = W_RESP;
        else                                                           wr_next_s = W_DATA;
      end
      W_RESP: begin
        if (sub_resp_i.b_valid && wr_sel_b_ready_s) wr_next_s = W_IDLE;
        else                                        wr_next_s = W_RESP;
      end
      E_DATA: begin
        if (wr_sel_w_valid_s && wr_sel_w_last_s) wr_next_s = E_RESP;
        else                                     wr_next_s = E_DATA;
      end
      E_RESP: begin
        if (wr_sel_b_ready_s) wr_next_s = W_IDLE;
        else                  wr_next_s = E_RESP;
      end
      default: wr_next_s = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    rd_next_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (rd_grant_s) rd_next_s = R_AR;
        else            rd_next_s = R_IDLE;
      end
      R_AR: begin
        if (sub_resp_i.ar_ready) rd_next_s = R_DATA;
        else                     rd_next_s = R_AR;
      end
      R_DATA: begin
        if (sub_resp_i.r_valid && rd_sel_r_ready_s && sub_resp_i.r.last) rd_next_s = R_IDLE;
        else                                                             rd_next_s = R_DATA;
      end
      default: rd_next_s = R_IDLE;
    endcase
  end

  // Channel routing toward the subordinate and both managers
  always_comb begin
    sub_req_o     = '0;
    mgr_resp_s[0] = '0;
    mgr_resp_s[1] = '0;
    case (wr_state_r)
      W_AW: begin
        sub_req_o.aw       = wr_aw_r;
        sub_req_o.aw_valid = 1'b1;
      end
      W_DATA: begin
        sub_req_o.w       = wr_sel_r ? mgr1_req_i.w : mgr0_req_i.w;
        sub_req_o.w_valid = wr_sel_w_valid_s;
      end
      W_RESP:  sub_req_o.b_ready = wr_sel_b_ready_s;
      default: sub_req_o.aw_valid = 1'b0;
    endcase
    case (rd_state_r)
      R_AR: begin
        sub_req_o.ar       = rd_ar_r;
        sub_req_o.ar_valid = 1'b1;
      end
      R_DATA:  sub_req_o.r_ready = rd_sel_r_ready_s;
      default: sub_req_o.ar_valid = 1'b0;
    endcase
    for (int m = 0; m < 2; m++) begin
      mgr_resp_s[m].aw_ready = wr_grant_s && (wr_win_s == 1'(m));
      mgr_resp_s[m].ar_ready = rd_grant_s && (rd_win_s == 1'(m));
      mgr_resp_s[m].w_ready  = (wr_sel_r == 1'(m)) &&
                               (((wr_state_r == W_DATA) && sub_resp_i.w_ready) || (wr_state_r == E_DATA));
      mgr_resp_s[m].b_valid  = (wr_sel_r == 1'(m)) &&
                               (((wr_state_r == W_RESP) && sub_resp_i.b_valid) || (wr_state_r == E_RESP));
      if ((wr_sel_r == 1'(m)) && (wr_state_r == W_RESP)) begin
        mgr_resp_s[m].b = sub_resp_i.b;
      end else if ((wr_sel_r == 1'(m)) && (wr_state_r == E_RESP)) begin
        mgr_resp_s[m].b.id   = wr_id_r;
        mgr_resp_s[m].b.resp = 2'b10;
      end else begin
        mgr_resp_s[m].b = '0;
      end
      if ((rd_sel_r == 1'(m)) && (rd_state_r == R_DATA)) begin
        mgr_resp_s[m].r_valid = sub_resp_i.r_valid;
        mgr_resp_s[m].r       = sub_resp_i.r;
      end else begin
        mgr_resp_s[m].r_valid = 1'b0;
        mgr_resp_s[m].r       = '0;
      end
    end
  end

  assign mgr0_resp_o = mgr_resp_s[0];
  assign mgr1_resp_o = mgr_resp_s[1];
  assign busy_o      = {rd_state_r != R_IDLE, wr_state_r != W_IDLE};

endmodule

// File: tb/tb_core_v_mcu_axi_arb2.sv
// Directed bench for core_v_mcu_axi_arb2 with a responding subordinate model and
// queue scoreboards for the sub AW/W/AR channels and the manager B/R channels.
module tb_core_v_mcu_axi_arb2;
  import core_v_mcu_axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  axi_req_t   mreq [2];
  axi_resp_t  mresp [2];
  axi_req_t   sreq;
  axi_resp_t  sresp;
  logic [1:0] busy;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int n_sub_aw = 0;
  logic w_toggle = 1'b0;

  logic [35:0] q_aw [$];   // {id, addr}
  logic [32:0] q_w  [$];   // {data, last}
  logic [31:0] q_ar [$];   // addr
  logic [6:0]  q_b  [$];   // {mgr, id, resp}
  logic [33:0] q_r  [$];   // {mgr, data, last}

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_v_mcu_axi_arb2 dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mgr0_req_i  (mreq[0]),
    .mgr0_resp_o (mresp[0]),
    .mgr1_req_i  (mreq[1]),
    .mgr1_resp_o (mresp[1]),
    .sub_req_o   (sreq),
    .sub_resp_i  (sresp),
    .busy_o      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake pops the oldest expectation of its channel
  always @(negedge clk) begin
    if (rst_n) begin
      if (sreq.aw_valid && sresp.aw_ready) begin
        n_sub_aw++;
        if (q_aw.size() == 0) chk("sub_aw_unexpected", 64'd1, 64'd0);
        else chk("sub_aw", {28'd0, sreq.aw.id, sreq.aw.addr}, {28'd0, q_aw.pop_front()});
      end
      if (sreq.w_valid && sresp.w_ready) begin
        if (q_w.size() == 0) chk("sub_w_unexpected", 64'd1, 64'd0);
        else chk("sub_w", {31'd0, sreq.w.data, sreq.w.last}, {31'd0, q_w.pop_front()});
      end
      if (sreq.ar_valid && sresp.ar_ready) begin
        if (q_ar.size() == 0) chk("sub_ar_unexpected", 64'd1, 64'd0);
        else chk("sub_ar", {32'd0, sreq.ar.addr}, {32'd0, q_ar.pop_front()});
      end
      for (int m = 0; m < 2; m++) begin
        if (mresp[m].b_valid && mreq[m].b_ready) begin
          if (q_b.size() == 0) chk("mgr_b_unexpected", 64'd1, 64'd0);
          else chk("mgr_b", {57'd0, 1'(m), mresp[m].b.id, mresp[m].b.resp}, {57'd0, q_b.pop_front()});
        end
        if (mresp[m].r_valid && mreq[m].r_ready) begin
          if (q_r.size() == 0) chk("mgr_r_unexpected", 64'd1, 64'd0);
          else chk("mgr_r", {30'd0, 1'(m), mresp[m].r.data, mresp[m].r.last}, {30'd0, q_r.pop_front()});
        end
      end
    end
  end

  // Subordinate model: accepts AW/AR at once, returns B after W last, R beats = addr + beat
  initial begin : sub_model
    automatic logic [3:0]  bid = 4'd0, rid = 4'd0, cap_aw_id = 4'd0, cap_ar_id = 4'd0;
    automatic logic [31:0] raddr = 32'd0, cap_ar_addr = 32'd0;
    automatic logic [7:0]  rlen = 8'd0, rbeat = 8'd0, cap_ar_len = 8'd0;
    automatic logic        bpend = 1'b0;
    automatic logic        rst_s, aw_hs, wl_hs, b_hs, ar_hs, r_hs;
    sresp = '0;
    sresp.aw_ready = 1'b1;
    sresp.ar_ready = 1'b1;
    sresp.w_ready  = 1'b1;
    forever begin
      @(negedge clk);
      rst_s = rst_n;
      aw_hs = sreq.aw_valid && sresp.aw_ready;
      wl_hs = sreq.w_valid && sresp.w_ready && sreq.w.last;
      b_hs  = sresp.b_valid && sreq.b_ready;
      ar_hs = sreq.ar_valid && sresp.ar_ready;
      r_hs  = sresp.r_valid && sreq.r_ready;
      cap_aw_id = sreq.aw.id;
      cap_ar_id = sreq.ar.id;
      cap_ar_addr = sreq.ar.addr;
      cap_ar_len = sreq.ar.len;
      @(posedge clk);
      #1;
      if (!rst_s) begin
        sresp.b_valid = 1'b0;
        sresp.r_valid = 1'b0;
        bpend = 1'b0;
      end else begin
        if (aw_hs) bid = cap_aw_id;
        if (wl_hs) bpend = 1'b1;
        if (b_hs) sresp.b_valid = 1'b0;
        if (bpend && !sresp.b_valid) begin
          sresp.b_valid = 1'b1;
          sresp.b.id    = bid;
          sresp.b.resp  = 2'b00;
          bpend = 1'b0;
        end
        if (r_hs) begin
          if (sresp.r.last) sresp.r_valid = 1'b0;
          else begin
            rbeat = rbeat + 8'd1;
            sresp.r.data = raddr + {24'd0, rbeat};
            sresp.r.last = (rbeat == rlen);
          end
        end
        if (ar_hs) begin
          rid = cap_ar_id; raddr = cap_ar_addr; rlen = cap_ar_len; rbeat = 8'd0;
          sresp.r_valid = 1'b1;
          sresp.r.id    = rid;
          sresp.r.data  = raddr;
          sresp.r.last  = (rlen == 8'd0);
        end
      end
      sresp.w_ready = w_toggle ? ~sresp.w_ready : 1'b1;
    end
  end

  task automatic send_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [5:0] atop, output int t);
    t = -1;
    mreq[m].aw = '0;
    mreq[m].aw.id = id; mreq[m].aw.addr = addr; mreq[m].aw.len = len; mreq[m].aw.atop = atop;
    mreq[m].aw_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mresp[m].aw_ready) begin
        t = cyc;
        @(posedge clk); #1;
        mreq[m].aw_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    mreq[m].aw_valid = 1'b0;
    chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_ar(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, output int t);
    t = -1;
    mreq[m].ar = '0;
    mreq[m].ar.id = id; mreq[m].ar.addr = addr; mreq[m].ar.len = len;
    mreq[m].ar_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mresp[m].ar_ready) begin
        t = cyc;
        @(posedge clk); #1;
        mreq[m].ar_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    mreq[m].ar_valid = 1'b0;
    chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input int m, input int n, input int total, input logic [31:0] base);
    for (int b = 0; b < n; b++) begin
      automatic bit done = 1'b0;
      mreq[m].w = '0;
      mreq[m].w.data = base + 32'(b);
      mreq[m].w.last = (b == total - 1);
      mreq[m].w_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clk);
        done = mresp[m].w_ready;
        @(posedge clk); #1;
      end
      if (!done) chk("w_timeout", 64'd0, 64'd1);
    end
    mreq[m].w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy == 2'b00 && q_aw.size() == 0 && q_w.size() == 0 && q_ar.size() == 0 &&
          q_b.size() == 0 && q_r.size() == 0 && !sresp.b_valid && !sresp.r_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin : stim
    int t0a, t0b, t1, n0;
    mreq[0] = '0; mreq[1] = '0;
    mreq[0].b_ready = 1'b1; mreq[0].r_ready = 1'b1;
    mreq[1].b_ready = 1'b1; mreq[1].r_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_sub_valids", 64'({sreq.aw_valid, sreq.w_valid, sreq.ar_valid, sreq.b_ready, sreq.r_ready}), 64'd0);
    chk("reset_mgr_outs", 64'({mresp[0].w_ready, mresp[0].b_valid, mresp[0].r_valid,
                               mresp[1].w_ready, mresp[1].b_valid, mresp[1].r_valid}), 64'd0);
    @(posedge clk); #1;

    // single write from mgr0
    q_aw.push_back({4'd3, 32'h1000});
    q_w.push_back({32'hA0, 1'b0}); q_w.push_back({32'hA1, 1'b1});
    q_b.push_back({1'b0, 4'd3, 2'b00});
    fork
      begin
        send_aw(0, 4'd3, 32'h1000, 8'd1, 6'd0, t0a);
        chk("aw_latency_valid", 64'(sreq.aw_valid), 64'd1);
        chk("aw_latency_addr", 64'(sreq.aw.addr), 64'h1000);
        chk("busy_write", 64'(busy[0]), 64'd1);
      end
      send_w(0, 2, 2, 32'hA0);
    join
    wait_idle();
    chk("busy_after_write", 64'(busy), 64'd0);

    // read contention: expected grant order mgr0, mgr1, mgr0
    q_ar.push_back(32'h2000); q_ar.push_back(32'h3000); q_ar.push_back(32'h2100);
    q_r.push_back({1'b0, 32'h2000, 1'b1}); q_r.push_back({1'b1, 32'h3000, 1'b1});
    q_r.push_back({1'b0, 32'h2100, 1'b1});
    fork
      begin
        send_ar(0, 4'd1, 32'h2000, 8'd0, t0a);
        send_ar(0, 4'd2, 32'h2100, 8'd0, t0b);
      end
      send_ar(1, 4'd4, 32'h3000, 8'd0, t1);
    join
    chk("rr_order", 64'((t0a < t1) && (t1 < t0b)), 64'd1);
    wait_idle();

    // concurrent write (mgr0) and read (mgr1)
    q_aw.push_back({4'd7, 32'h4000});
    for (int b = 0; b < 4; b++) q_w.push_back({32'hB0 + 32'(b), b == 3});
    q_b.push_back({1'b0, 4'd7, 2'b00});
    q_ar.push_back(32'h5000);
    q_r.push_back({1'b1, 32'h5000, 1'b1});
    fork
      send_aw(0, 4'd7, 32'h4000, 8'd3, 6'd0, t0a);
      send_w(0, 4, 4, 32'hB0);
      send_ar(1, 4'd9, 32'h5000, 8'd0, t1);
    join
    chk("aw_ar_same_cycle", 64'(t0a), 64'(t1));
    wait_idle();

    // atomic from mgr1 is answered locally
    n0 = n_sub_aw;
    q_b.push_back({1'b1, 4'd5, 2'b10});
    fork
      send_aw(1, 4'd5, 32'h6000, 8'd0, 6'h20, t1);
      send_w(1, 1, 1, 32'hC0);
    join
    wait_idle();
    chk("atomic_no_sub_aw", 64'(n_sub_aw), 64'(n0));

    // backpressure: toggling sub w_ready, mgr0 holds off B
    w_toggle = 1'b1;
    mreq[0].b_ready = 1'b0;
    q_aw.push_back({4'd2, 32'h7000});
    for (int b = 0; b < 4; b++) q_w.push_back({32'hD0 + 32'(b), b == 3});
    q_b.push_back({1'b0, 4'd2, 2'b00});
    fork
      send_aw(0, 4'd2, 32'h7000, 8'd3, 6'd0, t0a);
      send_w(0, 4, 4, 32'hD0);
    join
    for (int i = 0; i < 50 && !mresp[0].b_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold_valid", 64'(mresp[0].b_valid), 64'd1);
      chk("b_hold_id", 64'(mresp[0].b.id), 64'd2);
    end
    @(posedge clk); #1;
    mreq[0].b_ready = 1'b1;
    wait_idle();
    w_toggle = 1'b0;

    // reset mid-burst; read pointer is first moved to mgr1 by a lone mgr0 read
    q_ar.push_back(32'h2200); q_r.push_back({1'b0, 32'h2200, 1'b1});
    send_ar(0, 4'd1, 32'h2200, 8'd0, t0a);
    wait_idle();
    q_aw.push_back({4'd1, 32'h8000});
    q_w.push_back({32'hE0, 1'b0});
    fork
      send_aw(0, 4'd1, 32'h8000, 8'd1, 6'd0, t0a);
      send_w(0, 1, 2, 32'hE0);
    join
    chk("busy_mid_burst", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sub_valids", 64'({sreq.aw_valid, sreq.w_valid, sreq.ar_valid, sreq.b_ready, sreq.r_ready}), 64'd0);
    chk("rst_mgr_outs", 64'({mresp[0].w_ready, mresp[0].b_valid, mresp[1].w_ready, mresp[1].b_valid}), 64'd0);
    @(posedge clk); #1;
    q_aw.push_back({4'd6, 32'h9000});
    q_w.push_back({32'hF0, 1'b1});
    q_b.push_back({1'b1, 4'd6, 2'b00});
    fork
      send_aw(1, 4'd6, 32'h9000, 8'd0, 6'd0, t1);
      send_w(1, 1, 1, 32'hF0);
    join
    chk("fresh_grant_mgr1", 64'(t1 > 0), 64'd1);
    wait_idle();
    // reset returned the read pointer to mgr0
    q_ar.push_back(32'hA000); q_ar.push_back(32'hB000);
    q_r.push_back({1'b0, 32'hA000, 1'b1}); q_r.push_back({1'b1, 32'hB000, 1'b1});
    fork
      send_ar(0, 4'd3, 32'hA000, 8'd0, t0a);
      send_ar(1, 4'd3, 32'hB000, 8'd0, t1);
    join
    chk("rst_ptr_mgr0_first", 64'(t0a < t1), 64'd1);
    wait_idle();
    chk("scoreboard_empty", 64'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
